// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one word read at a time to
// instruction memory and buffers returned instructions for the decode stage.
module inst_fetch_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             inst_valid_o,
    output logic [WIDTH-1:0] inst_o,
    output logic [WIDTH-1:0] pc_o,
    input  logic             inst_ready_i
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // Handshakes: the request is taken when imem_req_o && imem_gnt_i; a FIFO
    // entry moves to decode when inst_valid_o && inst_ready_i. Neither side
    // may retract its offer on the strength of the other's response.
    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0]  req_pc_q, req_pc_d;
    logic              drop_q, drop_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0]  mem_inst_q [FIFO_DEPTH];
    logic [WIDTH-1:0]  mem_inst_d [FIFO_DEPTH];
    logic [WIDTH-1:0]  mem_pc_q   [FIFO_DEPTH];
    logic [WIDTH-1:0]  mem_pc_d   [FIFO_DEPTH];

    logic              req_int;
    logic              valid_int;
    logic              push;
    logic              pop;

    assign valid_int = (count_q != '0);
    assign req_int   = (state_q == ST_REQ) && !redirect_i && (count_q < CW'(FIFO_DEPTH));
    assign pop       = valid_int && inst_ready_i;
    assign push      = (state_q == ST_WAIT) && imem_rvalid_i && !drop_q && !redirect_i;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_inst_d = mem_inst_q;
        mem_pc_d   = mem_pc_q;

        case (state_q)
            ST_REQ: begin
                if (req_int && imem_gnt_i) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + WIDTH'(4);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end else if (redirect_i) begin
                    // The in-flight response belongs to the old stream.
                    drop_d = 1'b1;
                end
            end
            default: state_d = ST_REQ;
        endcase

        if (push) begin
            mem_inst_d[wr_ptr_q] = imem_rdata_i;
            mem_pc_d[wr_ptr_q]   = req_pc_q;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~WIDTH'(3);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Buffer storage carries no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        mem_inst_q <= mem_inst_d;
        mem_pc_q   <= mem_pc_d;
    end

    assign imem_req_o   = !rst_n && req_int;
    assign imem_addr_o  = rst_n ? '0 : fetch_pc_q;
    assign inst_valid_o = !rst_n && valid_int;
    assign inst_o       = rst_n ? '0 : mem_inst_q[rd_ptr_q];
    assign pc_o         = rst_n ? '0 : mem_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: fetch order, backpressure, redirects,
// PC wrap and mid-operation reset.
module tb_inst_fetch_unit;

  localparam int W = 32;
  localparam logic [W-1:0] KEY = 32'hA5A5_A5A5;

  logic         clk;
  logic         rst_n;
  logic         redirect_i;
  logic [W-1:0] redirect_pc_i;
  logic         imem_req_o;
  logic [W-1:0] imem_addr_o;
  logic         imem_gnt_i;
  logic         imem_rvalid_i;
  logic [W-1:0] imem_rdata_i;
  logic         inst_valid_o;
  logic [W-1:0] inst_o;
  logic [W-1:0] pc_o;
  logic         inst_ready_i;

  int n_cmp = 0;
  int n_err = 0;
  logic         auto_en;
  logic [W-1:0] exp_q[$];

  inst_fetch_unit #(.WIDTH(W), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_ready_i (inst_ready_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; optionally play a memory that answers the cycle after grant.
  task automatic tick();
    logic         granted;
    logic [W-1:0] gaddr;
    granted = auto_en && imem_req_o && imem_gnt_i;
    gaddr   = imem_addr_o;
    @(posedge clk);
    #1;
    if (auto_en) begin
      imem_rvalid_i = granted;
      imem_rdata_i  = granted ? (gaddr ^ KEY) : '0;
    end
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b1;
    auto_en       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    inst_ready_i  = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    imem_gnt_i = 1'b1;
    inst_ready_i = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({imem_req_o, inst_valid_o} !== 2'b00) begin
      n_err++; $display("FAIL reset_ctl: req/valid=%b expected 00", {imem_req_o, inst_valid_o});
    end
    n_cmp++;
    if ({imem_addr_o, inst_o, pc_o} !== '0) begin
      n_err++; $display("FAIL reset_data: addr=%h inst=%h pc=%h expected all 0", imem_addr_o, inst_o, pc_o);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] exp_addr;
    logic         seen;
    int           ngnt;
    do_reset();
    imem_gnt_i = 1'b1;
    inst_ready_i = 1'b1;
    auto_en = 1'b1;
    settle();
    exp_addr = 32'h0;
    seen = 1'b0;
    ngnt = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0 + W'(4 * i));
    for (int c = 0; c < 7; c++) begin
      if (imem_req_o && imem_gnt_i && ngnt < 4) begin
        n_cmp++;
        if (imem_addr_o !== exp_addr) begin
          n_err++; $display("FAIL stream_addr: got %h expected %h", imem_addr_o, exp_addr);
        end
        exp_addr = exp_addr + 32'd4;
        ngnt++;
      end
      if (inst_valid_o && exp_q.size() > 0) begin
        if (!seen) begin
          n_cmp++;
          if (c !== 2) begin
            n_err++; $display("FAIL first_valid_cycle: got %0d expected 2", c);
          end
          seen = 1'b1;
        end
        n_cmp++;
        if (pc_o !== exp_q[0] || inst_o !== (exp_q[0] ^ KEY)) begin
          n_err++; $display("FAIL stream_pop: pc=%h inst=%h expected pc=%h inst=%h",
                            pc_o, inst_o, exp_q[0], exp_q[0] ^ KEY);
        end
        void'(exp_q.pop_front());
      end
      tick();
    end
    n_cmp++;
    if (ngnt !== 4 || !seen) begin
      n_err++; $display("FAIL stream_count: grants=%0d seen=%b expected 4/1", ngnt, seen);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int ngnt;
    do_reset();
    imem_gnt_i = 1'b1;
    inst_ready_i = 1'b0;
    auto_en = 1'b1;
    settle();
    ngnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (imem_req_o && imem_gnt_i) ngnt++;
      tick();
    end
    n_cmp++;
    if (ngnt !== 2) begin
      n_err++; $display("FAIL bp_grants: got %0d expected 2", ngnt);
    end
    n_cmp++;
    if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b1 || pc_o !== 32'h0) begin
      n_err++; $display("FAIL bp_hold: req=%b valid=%b pc=%h expected 0/1/0", imem_req_o, inst_valid_o, pc_o);
    end
    inst_ready_i = 1'b1;
    settle();
    n_cmp++;
    if (pc_o !== 32'h0 || inst_o !== (32'h0 ^ KEY)) begin
      n_err++; $display("FAIL bp_drain0: pc=%h inst=%h expected 0/%h", pc_o, inst_o, KEY);
    end
    tick();
    n_cmp++;
    if (pc_o !== 32'h4 || inst_o !== (32'h4 ^ KEY) || !inst_valid_o) begin
      n_err++; $display("FAIL bp_drain4: pc=%h inst=%h valid=%b expected 4", pc_o, inst_o, inst_valid_o);
    end
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
      n_err++; $display("FAIL bp_resume: req=%b addr=%h expected 1/8", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_gnt_i = 1'b1;
    settle();
    tick();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_1002;
    settle();
    n_cmp++;
    if (imem_req_o !== 1'b0) begin
      n_err++; $display("FAIL rdw_req: got %b expected 0", imem_req_o);
    end
    tick();
    redirect_i = 1'b0;
    tick();
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    imem_rvalid_i = 1'b0;
    settle();
    n_cmp++;
    if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h1000) begin
      n_err++; $display("FAIL rdw_drop: valid=%b req=%b addr=%h expected 0/1/1000",
                        inst_valid_o, imem_req_o, imem_addr_o);
    end
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h1234_5678;
    tick();
    imem_rvalid_i = 1'b0;
    settle();
    n_cmp++;
    if (inst_valid_o !== 1'b1 || pc_o !== 32'h1000 || inst_o !== 32'h1234_5678) begin
      n_err++; $display("FAIL rdw_first: valid=%b pc=%h inst=%h expected 1/1000/12345678",
                        inst_valid_o, pc_o, inst_o);
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    do_reset();
    imem_gnt_i = 1'b1;
    settle();
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hD000_0000;
    tick();
    imem_rvalid_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_2000;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hD000_0004;
    inst_ready_i = 1'b1;
    settle();
    n_cmp++;
    if (inst_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin
      n_err++; $display("FAIL rrp_pre: valid=%b req=%b expected 1/0", inst_valid_o, imem_req_o);
    end
    tick();
    redirect_i = 1'b0;
    imem_rvalid_i = 1'b0;
    inst_ready_i = 1'b0;
    settle();
    n_cmp++;
    if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h2000) begin
      n_err++; $display("FAIL rrp_flush: valid=%b req=%b addr=%h expected 0/1/2000",
                        inst_valid_o, imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] got[2];
    int ngnt;
    do_reset();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    imem_gnt_i = 1'b1;
    settle();
    n_cmp++;
    if (imem_req_o !== 1'b0) begin
      n_err++; $display("FAIL wrap_redir_req: got %b expected 0", imem_req_o);
    end
    tick();
    redirect_i = 1'b0;
    inst_ready_i = 1'b1;
    auto_en = 1'b1;
    settle();
    ngnt = 0;
    got[0] = '0;
    got[1] = '0;
    for (int c = 0; c < 6; c++) begin
      if (imem_req_o && imem_gnt_i && ngnt < 2) begin
        got[ngnt] = imem_addr_o;
        ngnt++;
      end
      tick();
    end
    n_cmp++;
    if (ngnt !== 2 || got[0] !== 32'hFFFF_FFFC || got[1] !== 32'h0) begin
      n_err++; $display("FAIL wrap_addr: n=%0d a0=%h a1=%h expected 2/fffffffc/0", ngnt, got[0], got[1]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    imem_gnt_i = 1'b1;
    settle();
    tick();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hA0A0_0000;
    tick();
    imem_rvalid_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    settle();
    n_cmp++;
    if (inst_valid_o !== 1'b1 || imem_req_o !== 1'b0) begin
      n_err++; $display("FAIL mr_pre: valid=%b req=%b expected 1/0", inst_valid_o, imem_req_o);
    end
    rst_n = 1'b1;
    settle();
    n_cmp++;
    if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      n_err++; $display("FAIL mr_during: valid=%b req=%b expected 0/0", inst_valid_o, imem_req_o);
    end
    tick();
    rst_n = 1'b0;
    settle();
    n_cmp++;
    if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_err++; $display("FAIL mr_after: valid=%b req=%b addr=%h expected 0/1/0",
                        inst_valid_o, imem_req_o, imem_addr_o);
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hBAD0_0004;
    tick();
    imem_rvalid_i = 1'b0;
    settle();
    n_cmp++;
    if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_err++; $display("FAIL mr_late_rvalid: valid=%b req=%b addr=%h expected 0/1/0",
                        inst_valid_o, imem_req_o, imem_addr_o);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    auto_en = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    inst_ready_i = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid_pop();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
